// File: rtl/vga_timing_param_if.sv
// Timing-generator bus: pixel enable in, position/sync/blanking/strobes out.
interface vga_timing_param_if #(
  parameter int unsigned CNT_W = 11
) ();
  logic             en;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hsync;
  logic             vsync;
  logic             hblnk;
  logic             vblnk;
  logic             de;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  en,
    output hcount, vcount, hsync, vsync, hblnk, vblnk, de, line_start, frame_start
  );

  modport slave (
    output en,
    input  hcount, vcount, hsync, vsync, hblnk, vblnk, de, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_param.sv
// Parametrised VGA/VESA timing generator; every output is decoded from the
// next position and registered together with the counters.
module vga_timing_param #(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned H_FP      = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BP      = 88,
  parameter int unsigned V_ACTIVE  = 600,
  parameter int unsigned V_FP      = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BP      = 23,
  parameter logic        HSYNC_POL = 1'b1,
  parameter logic        VSYNC_POL = 1'b1,
  parameter int unsigned CNT_W     = 11
) (
  input logic pclk,
  input logic rst,
  vga_timing_param_if.master bus
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_BP < 1) begin : g_bad_hbp
    $error("vga_timing_param: H_BP must be >= 1");
  end
  if (V_BP < 1) begin : g_bad_vbp
    $error("vga_timing_param: V_BP must be >= 1");
  end
  if (64'(H_TOTAL) > (64'(1) << CNT_W)) begin : g_bad_htot
    $error("vga_timing_param: H_TOTAL exceeds counter range");
  end
  if (64'(V_TOTAL) > (64'(1) << CNT_W)) begin : g_bad_vtot
    $error("vga_timing_param: V_TOTAL exceeds counter range");
  end

  // Back porch >= 1 keeps every sync end strictly below the total, so all fit CNT_W.
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             h_wrap;
  logic             hs_act;
  logic             vs_act;
  logic             hb_next;
  logic             vb_next;

  always_comb begin
    h_wrap  = (bus.hcount == H_LAST);
    h_next  = h_wrap ? '0 : bus.hcount + 1'b1;
    v_next  = bus.vcount;
    if (h_wrap) begin
      v_next = (bus.vcount == V_LAST) ? '0 : bus.vcount + 1'b1;
    end
    hs_act  = (h_next >= HS_BEG) && (h_next < HS_END);
    vs_act  = (v_next >= VS_BEG) && (v_next < VS_END);
    hb_next = (h_next >= H_ACT_C);
    vb_next = (v_next >= V_ACT_C);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      bus.hcount      <= H_LAST;
      bus.vcount      <= V_LAST;
      bus.hsync       <= ~HSYNC_POL;
      bus.vsync       <= ~VSYNC_POL;
      bus.hblnk       <= 1'b1;
      bus.vblnk       <= 1'b1;
      bus.de          <= 1'b0;
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
    end else if (bus.en) begin
      bus.hcount      <= h_next;
      bus.vcount      <= v_next;
      bus.hsync       <= HSYNC_POL ? hs_act : ~hs_act;
      bus.vsync       <= VSYNC_POL ? vs_act : ~vs_act;
      bus.hblnk       <= hb_next;
      bus.vblnk       <= vb_next;
      bus.de          <= ~hb_next & ~vb_next;
      bus.line_start  <= (h_next == '0);
      bus.frame_start <= (h_next == '0) && (v_next == '0);
    end else begin
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vga_timing_param.sv
// Scoreboard bench: four timing modes share rst/en; a position-index model
// predicts every output, a monitor compares each cycle.
module tb_vga_timing_param;
  localparam int N = 4;
  // 0: default 800x600, 1: tiny positive (H_TOTAL = 2^CNT_W), 2: 640x480 negative, 3: tiny negative
  localparam int HA [N] = '{800, 8, 640, 12};
  localparam int HF [N] = '{ 40, 2,  16,  2};
  localparam int HS [N] = '{128, 3,  96,  4};
  localparam int HB [N] = '{ 88, 3,  48,  3};
  localparam int VA [N] = '{600, 5, 480,  6};
  localparam int VF [N] = '{  1, 1,  10,  2};
  localparam int VS [N] = '{  4, 2,   2,  1};
  localparam int VB [N] = '{ 23, 2,  33,  3};
  localparam int HP [N] = '{  1, 1,   0,  0};
  localparam int VP [N] = '{  1, 1,   0,  0};

  typedef struct {
    logic [31:0] h;
    logic [31:0] v;
    logic hs, vs, hb, vb, de, ls, fs;
  } obs_t;

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  logic en   = 1'b0;
  int checks = 0;
  int errors = 0;

  obs_t q [N][$];
  int   mh [N];
  int   mv [N];

  always #5 pclk = ~pclk;

  vga_timing_param_if #(.CNT_W(11)) b0 ();
  vga_timing_param_if #(.CNT_W(4))  b1 ();
  vga_timing_param_if #(.CNT_W(10)) b2 ();
  vga_timing_param_if #(.CNT_W(5))  b3 ();
  assign b0.en = en;
  assign b1.en = en;
  assign b2.en = en;
  assign b3.en = en;

  vga_timing_param #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(11)
  ) dut0 (.pclk(pclk), .rst(rst), .bus(b0));

  vga_timing_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(4)
  ) dut1 (.pclk(pclk), .rst(rst), .bus(b1));

  vga_timing_param #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(10)
  ) dut2 (.pclk(pclk), .rst(rst), .bus(b2));

  vga_timing_param #(
    .H_ACTIVE(12), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(1), .V_BP(3),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(5)
  ) dut3 (.pclk(pclk), .rst(rst), .bus(b3));

  function automatic obs_t predict(int k, int h, int v, bit ls, bit fs);
    obs_t e;
    bit hact, vact;
    hact = (h >= HA[k] + HF[k]) && (h < HA[k] + HF[k] + HS[k]);
    vact = (v >= VA[k] + VF[k]) && (v < VA[k] + VF[k] + VS[k]);
    e.h  = h;
    e.v  = v;
    e.hs = (HP[k] != 0) ? hact : !hact;
    e.vs = (VP[k] != 0) ? vact : !vact;
    e.hb = (h >= HA[k]);
    e.vb = (v >= VA[k]);
    e.de = !e.hb && !e.vb;
    e.ls = ls;
    e.fs = fs;
    return e;
  endfunction

  // Drive one cycle of stimulus and queue what every mode must show after the next edge.
  task automatic step(input bit r, input bit e);
    int ht, vt, p;
    bit ls, fs;
    rst = r;
    en  = e;
    for (int k = 0; k < N; k++) begin
      ht = HA[k] + HF[k] + HS[k] + HB[k];
      vt = VA[k] + VF[k] + VS[k] + VB[k];
      ls = 1'b0;
      fs = 1'b0;
      if (r) begin
        mh[k] = ht - 1;
        mv[k] = vt - 1;
      end else if (e) begin
        p     = (mv[k] * ht + mh[k] + 1) % (ht * vt);
        mh[k] = p % ht;
        mv[k] = p / ht;
        ls    = (mh[k] == 0);
        fs    = (p == 0);
      end
      q[k].push_back(predict(k, mh[k], mv[k], ls, fs));
    end
    @(negedge pclk);
  endtask

  task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %0d expected %0d", name, k, $time, act, exp);
    end
  endtask

  function automatic obs_t sample(int k);
    obs_t a;
    case (k)
      0: a = '{32'(b0.hcount), 32'(b0.vcount), b0.hsync, b0.vsync, b0.hblnk, b0.vblnk, b0.de, b0.line_start, b0.frame_start};
      1: a = '{32'(b1.hcount), 32'(b1.vcount), b1.hsync, b1.vsync, b1.hblnk, b1.vblnk, b1.de, b1.line_start, b1.frame_start};
      2: a = '{32'(b2.hcount), 32'(b2.vcount), b2.hsync, b2.vsync, b2.hblnk, b2.vblnk, b2.de, b2.line_start, b2.frame_start};
      default: a = '{32'(b3.hcount), 32'(b3.vcount), b3.hsync, b3.vsync, b3.hblnk, b3.vblnk, b3.de, b3.line_start, b3.frame_start};
    endcase
    return a;
  endfunction

  always @(posedge pclk) begin
    obs_t a, x;
    #1;
    for (int k = 0; k < N; k++) begin
      if (q[k].size() > 0) begin
        x = q[k].pop_front();
        a = sample(k);
        cmp("hcount",      k, a.h,         x.h);
        cmp("vcount",      k, a.v,         x.v);
        cmp("hsync",       k, 32'(a.hs),   32'(x.hs));
        cmp("vsync",       k, 32'(a.vs),   32'(x.vs));
        cmp("hblnk",       k, 32'(a.hb),   32'(x.hb));
        cmp("vblnk",       k, 32'(a.vb),   32'(x.vb));
        cmp("de",          k, 32'(a.de),   32'(x.de));
        cmp("line_start",  k, 32'(a.ls),   32'(x.ls));
        cmp("frame_start", k, 32'(a.fs),   32'(x.fs));
      end
    end
  end

  initial begin
    @(negedge pclk);
    repeat (3) step(1'b1, 1'b1);
    repeat (2200) step(1'b0, 1'b1);
    for (int i = 0; i < 600; i++) step(1'b0, 1'(i % 2 == 0));
    repeat (7) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (300) step(1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)));
    end
    step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b1);
    @(negedge pclk);
    for (int k = 0; k < N; k++) cmp("queue_drained", k, 32'(q[k].size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
